// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates an instruction-fetch port and a data port onto
//               one single-ported unified memory. Data wins by default. An
//               optional starvation guard is built when ARB_STARVE_GUARD_EN
//               is defined. It forces a fetch grant after MAX_WAIT
//               consecutive denied fetch cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  // instruction-fetch port
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  // data port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  // memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // Reject an out-of-range starvation limit at elaboration time.
  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_range
    $error("mem_port_arbiter: MAX_WAIT must lie in 1..15");
  end

  logic w_force_i;   // starvation limit reached: fetch overrides data
  logic i_pend_q, i_pend_d;
  logic d_pend_q, d_pend_d;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;

  // Count consecutive denied fetch cycles. Hold freezes the count.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!i_req || i_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (!hold && (wait_cnt_q != WAIT_LIMIT)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= 4'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign w_force_i = i_req && (wait_cnt_q == WAIT_LIMIT);
`else
  assign w_force_i = 1'b0;
`endif

  // Grant selection. Data wins unless the starvation guard forces the fetch.
  // Grants are suppressed during reset and hold.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst && !hold) begin
      if (d_req && !w_force_i) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  // Route the granted port onto the memory. Drive zeros when idle.
  always_comb begin
    mem_en    = i_gnt | d_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_addr  = i_addr;
    end
  end

  // Remember which port owns the read data returning next cycle.
  always_comb begin
    i_pend_d = i_gnt;
    d_pend_d = d_gnt && !d_we;
  end

  // Read-return ownership registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_pend_q <= 1'b0;
      d_pend_q <= 1'b0;
    end else begin
      i_pend_q <= i_pend_d;
      d_pend_q <= d_pend_d;
    end
  end

  // Return read data to its owner. Gating with rst drops any read that was
  // granted in the cycle before reset.
  always_comb begin
    i_rvalid = i_pend_q && !rst;
    d_rvalid = d_pend_q && !rst;
    i_rdata  = i_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter. The driver pushes
//               per-cycle grant/memory expectations and expected read data.
//               Monitors pop and compare on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hold = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt, i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural memory: synchronous write, registered one-cycle read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic          ig;
    logic          dg;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } cyc_t;

  cyc_t          cyc_q[$];
  logic [DW-1:0] i_exp_q[$];
  logic [DW-1:0] d_exp_q[$];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus plus the hand-computed grant outcome.
  task automatic step(input logic r, input logic h,
                      input logic ir, input logic [AW-1:0] ia,
                      input logic dr, input logic dw, input logic [AW-1:0] da,
                      input logic [DW-1:0] dwd,
                      input logic eig, input logic edg);
    cyc_t c;
    @(posedge clk);
    #1;
    rst = r; hold = h;
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    c.ig   = eig;
    c.dg   = edg;
    c.en   = eig | edg;
    c.we   = edg & dw;
    c.addr = edg ? da : (eig ? ia : '0);
    c.wd   = edg ? dwd : '0;
    cyc_q.push_back(c);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // Grant / memory-side monitor.
  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      cyc_t c;
      c = cyc_q.pop_front();
      chk("i_gnt",     {31'd0, i_gnt},  {31'd0, c.ig});
      chk("d_gnt",     {31'd0, d_gnt},  {31'd0, c.dg});
      chk("mem_en",    {31'd0, mem_en}, {31'd0, c.en});
      chk("mem_we",    {31'd0, mem_we}, {31'd0, c.we});
      chk("mem_addr",  {22'd0, mem_addr}, {22'd0, c.addr});
      chk("mem_wdata", mem_wdata, c.wd);
    end
  end

  // Read-return monitor: every rvalid must match a queued expectation.
  always @(negedge clk) begin
    if (i_rvalid) begin
      if (i_exp_q.size() == 0) chk("i_rvalid_unexpected", 32'd1, 32'd0);
      else chk("i_rdata", i_rdata, i_exp_q.pop_front());
    end else begin
      chk("i_rdata_idle", i_rdata, '0);
    end
    if (d_rvalid) begin
      if (d_exp_q.size() == 0) chk("d_rvalid_unexpected", 32'd1, 32'd0);
      else chk("d_rdata", d_rdata, d_exp_q.pop_front());
    end else begin
      chk("d_rdata_idle", d_rdata, '0);
    end
  end

  initial begin
    for (int a = 0; a < (1<<AW); a++) mem[a] = '0;
    mem[3] = 32'h3333_3333;
    mem[5] = 32'h1234_ABCD;
    mem[7] = 32'h0BAD_F00D;

    // Reset: both requests high, yet no grants and all outputs zero.
    step(1'b1, 1'b0, 1'b1, 10'd5, 1'b1, 1'b0, 10'd7, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

    // Fetch only, granted in the first cycle after reset.
    step(1'b0, 1'b0, 1'b1, 10'd5, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    i_exp_q.push_back(32'h1234_ABCD);
    idle();

    // Both request: load wins, then the fetch follows.
    step(1'b0, 1'b0, 1'b1, 10'd3, 1'b1, 1'b0, 10'd7, '0, 1'b0, 1'b1);
    d_exp_q.push_back(32'h0BAD_F00D);
    step(1'b0, 1'b0, 1'b1, 10'd3, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    i_exp_q.push_back(32'h3333_3333);
    idle();

    // Store gives no rvalid; a fetch from the same word sees the new data.
    step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 10'd9, 32'hDEAD_BEEF, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 10'd9, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    i_exp_q.push_back(32'hDEAD_BEEF);
    idle();

    // Continuous contention over ten cycles.
    for (int k = 0; k < 10; k++) begin
`ifdef ARB_STARVE_GUARD_EN
      if (k % 5 == 4) begin
        step(1'b0, 1'b0, 1'b1, 10'd5, 1'b1, 1'b0, 10'd7, '0, 1'b1, 1'b0);
        i_exp_q.push_back(32'h1234_ABCD);
      end else begin
        step(1'b0, 1'b0, 1'b1, 10'd5, 1'b1, 1'b0, 10'd7, '0, 1'b0, 1'b1);
        d_exp_q.push_back(32'h0BAD_F00D);
      end
`else
      step(1'b0, 1'b0, 1'b1, 10'd5, 1'b1, 1'b0, 10'd7, '0, 1'b0, 1'b1);
      d_exp_q.push_back(32'h0BAD_F00D);
`endif
    end
    idle();

    // The load is granted, then hold for 3 cycles: rvalid is still delivered.
    step(1'b0, 1'b0, 1'b1, 10'd5, 1'b1, 1'b0, 10'd7, '0, 1'b0, 1'b1);
    d_exp_q.push_back(32'h0BAD_F00D);
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b1, 1'b1, 10'd5, 1'b1, 1'b0, 10'd7, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 10'd5, 1'b1, 1'b0, 10'd7, '0, 1'b0, 1'b1);
    d_exp_q.push_back(32'h0BAD_F00D);
    idle();

    // Reset right after a fetch grant drops that read; grants resume on release.
    step(1'b0, 1'b0, 1'b1, 10'd5, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 10'd5, 1'b1, 1'b0, 10'd7, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 10'd5, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 10'd5, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    i_exp_q.push_back(32'h1234_ABCD);
    idle();
    idle();

    @(posedge clk);
    #6;
    // Every expected read must have been returned.
    chk("i_exp_left", i_exp_q.size(), 32'd0);
    chk("d_exp_left", d_exp_q.size(), 32'd0);
    chk("cyc_left",   cyc_q.size(),   32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
